// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encoding for the UART receive path.
//   OVERSAMPLE  ticks per bit period
//   HALF_BIT    ticks from the start edge to the start-bit centre
//   DATA_W      payload width
//   uart_rx_state_e  receiver FSM states (PARITY is only entered when
//                    UART_RX_PARITY_EN is defined)
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int HALF_BIT   = 8;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//   clk    system clock
//   rst    asynchronous active-low reset
//   clear  restart the count so the tick phase follows the start edge
//   tick   1-cycle pulse every CLKS_PER_TICK clocks
module uart_baud_tick #(
  parameter int CLKS_PER_TICK = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clear || cnt == TERM) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == TERM) && !clear;
endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 16x oversampled UART receiver with a one-byte AXI-Stream
// output register.
//   clk, rst          system clock, asynchronous active-low reset
//   uart_rxd          asynchronous serial input, idle high
//   m_axis_tdata/tvalid/tready  received byte stream
//   frame_err         1-cycle pulse: stop bit sampled low
//   parity_err        1-cycle pulse: even parity mismatch (0 unless built
//                     with UART_RX_PARITY_EN)
//   overrun_err       1-cycle pulse: byte dropped, output register full
// Build option: define UART_RX_PARITY_EN for 8E1 frames (default 8N1).
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rxd,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err
);
  uart_rx_state_e state, state_nxt;

  logic              rxd_meta, rxd_s;
  logic              tick, tick_clr;
  logic [3:0]        os_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              os_clr, sample, deliver, frame_hit;
  logic              os_half, os_last;
  logic              par_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clr),
    .tick  (tick)
  );

  assign os_half = tick && (os_cnt == 4'(HALF_BIT - 1));
  assign os_last = tick && (os_cnt == 4'(OVERSAMPLE - 1));

`ifdef UART_RX_PARITY_EN
  logic par_hit;
`endif

  always_comb begin
    state_nxt = state;
    tick_clr  = 1'b0;
    os_clr    = 1'b0;
    sample    = 1'b0;
    deliver   = 1'b0;
    frame_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_hit   = 1'b0;
`endif
    case (state)
      IDLE: if (!rxd_s) begin
        tick_clr  = 1'b1;
        os_clr    = 1'b1;
        state_nxt = START;
      end
      // Re-check the line at mid start bit; a high here is a glitch.
      START: if (os_half) begin
        os_clr    = 1'b1;
        state_nxt = rxd_s ? IDLE : DATA;
      end
      DATA: if (os_last) begin
        sample = 1'b1;
        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (os_last) begin
        par_hit   = (rxd_s != ^shift);
        state_nxt = STOP;
      end
`endif
      // Returning to IDLE at mid stop bit lets a back-to-back start edge
      // be seen on time.
      STOP: if (os_last) begin
        if (rxd_s) begin
          deliver   = !par_bad;
          state_nxt = IDLE;
        end else begin
          frame_hit = 1'b1;
          state_nxt = WAIT_IDLE;
        end
      end
      // A held-low line (break) reports once, then waits for idle.
      WAIT_IDLE: if (rxd_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (os_clr)    os_cnt <= '0;
      else if (tick) os_cnt <= os_cnt + 1'b1;
      if (os_clr)    bit_cnt <= '0;
      else if (sample) begin
        shift[bit_cnt] <= rxd_s;
        bit_cnt        <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // par_bad remembers the mismatch until the stop sample drops the byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_hit;
      if (tick_clr)     par_bad <= 1'b0;
      else if (par_hit) par_bad <= 1'b1;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      frame_err     <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      frame_err   <= frame_hit;
      overrun_err <= deliver && m_axis_tvalid && !m_axis_tready;
      // A same-cycle accept frees the register for the incoming byte.
      if (deliver && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata  <= shift;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_axis.sv
module tb_uart_rx_axis;
  import uart_pkg::*;

  localparam int CPT      = 4;
  localparam int BIT_CLKS = CPT * OVERSAMPLE;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       frame_err, parity_err, overrun_err;

  int total = 0;
  int bad   = 0;
  int beats = 0, n_fe = 0, n_pe = 0, n_oe = 0;
  logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
  logic flip_par = 1'b0;
`endif

  uart_rx_axis #(.CLKS_PER_TICK(CPT)) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rxd      (uart_rxd),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .overrun_err   (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: count error pulses and pop the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err)   n_fe++;
      if (parity_err)  n_pe++;
      if (overrun_err) n_oe++;
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_beat observed=%0h expected=none", m_axis_tdata);
        end
        if (exp_q.size() > 0) check("beat_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rxd = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      step(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ flip_par;
    step(BIT_CLKS);
`endif
    uart_rxd = stop;
    step(BIT_CLKS);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1);
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step(1);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    int exp_beats = 0;

    // Reset state
    step(5);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_errs", {29'd0, frame_err, parity_err, overrun_err}, 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b1;
    step(20);

    // Single byte, consumer ready
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    drain("a5_drain", 4 * BIT_CLKS);
    exp_beats++;
    check("a5_beats", 32'(beats), 32'(exp_beats));
    check("a5_errs", 32'(n_fe + n_oe + n_pe), 32'd0);

    // Back-to-back frames with the consumer stalled: second byte overruns
    m_axis_tready = 1'b0;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    send_byte(8'hC3);
    step(BIT_CLKS);
    check("ovr_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("ovr_tdata", 32'(m_axis_tdata), 32'h3C);
    check("ovr_pulses", 32'(n_oe), 32'd1);
    m_axis_tready = 1'b1;
    drain("ovr_drain", 16);
    exp_beats++;
    step(2);
    check("ovr_tvalid_drop", 32'(m_axis_tvalid), 32'd0);
    check("ovr_beats", 32'(beats), 32'(exp_beats));

    // Short low glitch is rejected silently
    uart_rxd = 1'b0;
    step(6);
    uart_rxd = 1'b1;
    step(4 * BIT_CLKS);
    check("glitch_beats", 32'(beats), 32'(exp_beats));
    check("glitch_errs", 32'(n_fe + n_pe), 32'd0);
    check("glitch_state", 32'(dut.state), 32'(IDLE));

    // Low stop bit followed by a break: one frame error only
    send_frame(8'h55, 1'b0);
    step(3 * 11 * BIT_CLKS);
    check("brk_fe", 32'(n_fe), 32'd1);
    check("brk_beats", 32'(beats), 32'(exp_beats));
    check("brk_state", 32'(dut.state), 32'(WAIT_IDLE));
    uart_rxd = 1'b1;
    step(2 * BIT_CLKS);
    check("brk_idle", 32'(dut.state), 32'(IDLE));
    exp_q.push_back(8'h01);
    send_byte(8'h01);
    drain("brk_drain", 4 * BIT_CLKS);
    exp_beats++;
    check("brk_recover", 32'(beats), 32'(exp_beats));
    check("brk_fe_after", 32'(n_fe), 32'd1);

`ifdef UART_RX_PARITY_EN
    // Wrong even-parity bit drops the byte
    flip_par = 1'b1;
    send_byte(8'h07);
    step(BIT_CLKS);
    check("par_pulse", 32'(n_pe), 32'd1);
    check("par_beats", 32'(beats), 32'(exp_beats));
    check("par_fe", 32'(n_fe), 32'd1);
    flip_par = 1'b0;
    exp_q.push_back(8'h07);
    send_byte(8'h07);
    drain("par_drain", 4 * BIT_CLKS);
    exp_beats++;
    check("par_ok_beats", 32'(beats), 32'(exp_beats));
`endif
    check("par_total", 32'(n_pe), 32'(`ifdef UART_RX_PARITY_EN 1 `else 0 `endif));

    // Reset while a byte is held and another frame is mid-DATA
    m_axis_tready = 1'b0;
    send_byte(8'h11);
    step(BIT_CLKS);
    check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("hold_tdata", 32'(m_axis_tdata), 32'h11);
    v = 8'h33;
    uart_rxd = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = v[i];
      step(BIT_CLKS);
    end
    step(BIT_CLKS / 2);
    check("mid_state", 32'(dut.state), 32'(DATA));
    rst = 1'b0;
    #1;
    check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("arst_tdata", 32'(m_axis_tdata), 32'd0);
    uart_rxd = 1'b1;
    step(5);
    rst = 1'b1;
    step(2 * BIT_CLKS);
    m_axis_tready = 1'b1;
    exp_q.push_back(8'h22);
    send_byte(8'h22);
    drain("post_rst_drain", 4 * BIT_CLKS);
    exp_beats++;
    check("post_rst_beats", 32'(beats), 32'(exp_beats));
    check("final_oe", 32'(n_oe), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

UART receiver that converts the serial host link into the 8-bit AXI-Stream byte flow consumed by axis_rx. It sits directly upstream of axis_rx. Its m_axis_* port connects to axis_rx's s_axis_* input. It performs 16x oversampled start/data/stop recovery and holds one received byte until the consumer accepts it. Framing and overrun problems are flagged as single-cycle pulses for status counters.

## Interface
- CLKS_PER_TICK, 54, clk cycles per oversample tick (100 MHz / (115200 × 16)); legal range ≥ 2
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- uart_rxd  in  1  asynchronous serial input, idle high
- m_axis_tdata  out  8  received byte
- m_axis_tvalid  out  1  byte available
- m_axis_tready  in  1  consumer accepts byte
- frame_err  out  1  1-cycle pulse, stop bit sampled low
- parity_err  out  1  1-cycle pulse, parity mismatch; constant 0 without UART_RX_PARITY_EN
- overrun_err  out  1  1-cycle pulse, new byte lost because the output register was full

## Operation
- Reset values: m_axis_tdata 0, m_axis_tvalid 0, all error pulses 0, state IDLE, sync flops 1, counters 0.
- uart_rxd passes through a 2-flop synchronizer. Only the synchronized value (rxd_s) is used.
- A tick counter counts 0..CLKS_PER_TICK-1 and issues a 1-cycle tick at terminal count. It is cleared on start detection so that tick phase aligns to the start edge.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- IDLE: when rxd_s == 0, clear the tick and oversample counters and go to START.
- START: on the 8th tick, if rxd_s == 0 go to DATA with bit_cnt = 0. If rxd_s == 1, it was a glitch; return to IDLE with no error.
- DATA: every 16 ticks, sample rxd_s into shift register bit bit_cnt (LSB first). After bit 7, go to PARITY if enabled, otherwise STOP.
- STOP: sample after 16 ticks.
  - If 1 and no parity error: deliver the byte and go to IDLE. The next start bit can therefore be detected half a bit early, which allows back-to-back frames.
  - If 0: pulse frame_err, drop the byte, and go to WAIT_IDLE.
- WAIT_IDLE: stay until rxd_s == 1, then go to IDLE. A break condition (line held low) produces exactly one frame_err.
- Deliver, output register empty: load tdata and set tvalid.
- Deliver, tvalid && tready in the same cycle: load the new byte. tvalid stays 1 and the old byte counts as accepted.
- Deliver, tvalid && !tready: keep the old byte, discard the new one, and pulse overrun_err.
- tvalid clears on the cycle after tvalid && tready, unless a deliver occurs in that same cycle.
- tdata is stable while tvalid == 1 && tready == 0.

## Timing
- Sync latency: 2 clk.
- Stop sample point: 9.5 bit periods after the synchronized start edge (8.5 + 1 for the stop bit), within ±1 tick.
- m_axis_tvalid rises 1 clk after the stop-sample cycle.
- Error pulses are asserted on the clk after the offending sample, for exactly 1 cycle.
- Reset deasserted mid-frame: the receiver resumes in IDLE. If the line is low at that point, the remaining low bits may be read as a start bit. The bench tolerates either a glitch-reject or a frame_err, but never a delivered byte.
- Asserting rst mid-frame or mid-hold discards all data immediately, asynchronously.

## Configuration
- UART_RX_PARITY_EN defined:
  - An even-parity bit follows bit 7 and is sampled 16 ticks after it (PARITY state).
  - On mismatch, pulse parity_err, still sample the stop bit, and drop the byte. A low stop bit also raises frame_err.
  - The stop sample moves to 10.5 bit periods.
- UART_RX_PARITY_EN undefined:
  - No PARITY state and an 8N1 frame.
  - parity_err is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - the state enum uart_rx_state_e
  - OVERSAMPLE = 16 and HALF_BIT = 8
  - the data width constant 8
- Sub-module uart_baud_tick holds the tick counter. Its inputs are clk, rst and clear. Its output is the tick.

## Test plan
- CLKS_PER_TICK = 4, send 0xA5 as 8N1 with tready held 1 → one tvalid beat with tdata 0xA5, no errors.
- Send 0x3C then 0xC3 back-to-back with tready = 0 → tdata stays 0x3C, overrun_err pulses once. Raise tready → one beat 0x3C, then tvalid drops.
- Drive a 6-clk low glitch on uart_rxd → no tvalid, no error pulses, state returns to IDLE.
- Send 0x55 with the stop bit forced low, then hold the line low for 3 frames → frame_err pulses exactly once, no tvalid. Release the line high and send 0x01 → 0x01 is delivered.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 → parity_err pulses once, no tvalid. Send 0x07 with parity bit 1 → 0x07 is delivered.
- Assert rst mid-DATA while tvalid holds 0x11 → tvalid drops to 0 immediately, tdata reads 0. The next clean frame 0x22 is delivered.
